// File: rtl/smpl_mem_arbiter_if.sv
// Requester and RAM-side signal bundle for smpl_mem_arbiter.
// slave is the arbiter's view; master is the requesters/RAM view.
interface smpl_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 16
);
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_gnt;
   logic              f_rvalid;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;

   logic              l_req;
   logic              l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_gnt;
   logic              l_rvalid;

   logic [DATA_W-1:0] rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  f_req, f_addr,
      input  d_req, d_we, d_addr, d_wdata,
      input  l_req, l_we, l_addr, l_wdata,
      input  mem_rdata,
      output f_gnt, f_rvalid, d_gnt, d_rvalid, l_gnt, l_rvalid,
      output rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output f_req, f_addr,
      output d_req, d_we, d_addr, d_wdata,
      output l_req, l_we, l_addr, l_wdata,
      output mem_rdata,
      input  f_gnt, f_rvalid, d_gnt, d_rvalid, l_gnt, l_rvalid,
      input  rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/smpl_mem_arbiter.sv
// Three-way arbiter for one single-port synchronous RAM: loader priority, fetch/data
// round-robin, wait counters that force a grant, registered command, tagged read return.
module smpl_mem_arbiter #(
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MAX_WAIT = 4
) (
   input logic                clock,
   input logic                reset,
   smpl_mem_arbiter_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WaitMax = CNT_W'(MAX_WAIT);

   typedef enum logic [1:0] {OwnFetch, OwnData, OwnLoad} owner_e;

   logic [CNT_W-1:0]  f_wait_q, f_wait_d, d_wait_q, d_wait_d, l_wait_q, l_wait_d;
   logic              rr_data_last_q, rr_data_last_d;
   logic              f_gnt, d_gnt, l_gnt;
   logic              f_sat, d_sat, l_sat;
   logic              hs, sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   owner_e            sel_own;

   logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              ret1_vld_q, ret1_vld_d, ret2_vld_q;
   owner_e            ret1_own_q, ret1_own_d, ret2_own_q;

   function automatic logic [CNT_W-1:0] next_wait(input logic req, input logic gnt,
                                                   input logic [CNT_W-1:0] cnt);
      if (!req || gnt) return '0;
      if (cnt == WaitMax) return cnt;
      return cnt + 1'b1;
   endfunction

   assign f_sat = bus.f_req && (f_wait_q == WaitMax);
   assign d_sat = bus.d_req && (d_wait_q == WaitMax);
   assign l_sat = bus.l_req && (l_wait_q == WaitMax);

   always_comb begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
      l_gnt = 1'b0;
      if (!reset) begin
         if (f_sat)                         f_gnt = 1'b1;
         else if (d_sat)                    d_gnt = 1'b1;
         else if (l_sat)                    l_gnt = 1'b1;
         else if (bus.l_req)                l_gnt = 1'b1;
         else if (bus.f_req && bus.d_req) begin
            // Whoever was not granted last wins the contention.
            if (rr_data_last_q) f_gnt = 1'b1;
            else                d_gnt = 1'b1;
         end
         else if (bus.f_req)                f_gnt = 1'b1;
         else if (bus.d_req)                d_gnt = 1'b1;
      end
   end

   always_comb begin
      hs        = f_gnt | d_gnt | l_gnt;
      sel_we    = 1'b0;
      sel_addr  = bus.f_addr;
      sel_wdata = '0;
      sel_own   = OwnFetch;
      if (d_gnt) begin
         sel_we    = bus.d_we;
         sel_addr  = bus.d_addr;
         sel_wdata = bus.d_wdata;
         sel_own   = OwnData;
      end else if (l_gnt) begin
         sel_we    = bus.l_we;
         sel_addr  = bus.l_addr;
         sel_wdata = bus.l_wdata;
         sel_own   = OwnLoad;
      end

      f_wait_d       = next_wait(bus.f_req, f_gnt, f_wait_q);
      d_wait_d       = next_wait(bus.d_req, d_gnt, d_wait_q);
      l_wait_d       = next_wait(bus.l_req, l_gnt, l_wait_q);
      rr_data_last_d = f_gnt ? 1'b0 : (d_gnt ? 1'b1 : rr_data_last_q);

      mem_en_d    = hs;
      mem_we_d    = hs & sel_we;
      mem_addr_d  = hs ? sel_addr : mem_addr_q;
      mem_wdata_d = (hs && sel_we) ? sel_wdata : mem_wdata_q;
      ret1_vld_d  = hs & ~sel_we;
      ret1_own_d  = sel_own;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         f_wait_q       <= '0;
         d_wait_q       <= '0;
         l_wait_q       <= '0;
         rr_data_last_q <= 1'b1;
         mem_en_q       <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         ret1_vld_q     <= 1'b0;
         ret1_own_q     <= OwnFetch;
         ret2_vld_q     <= 1'b0;
         ret2_own_q     <= OwnFetch;
      end else begin
         f_wait_q       <= f_wait_d;
         d_wait_q       <= d_wait_d;
         l_wait_q       <= l_wait_d;
         rr_data_last_q <= rr_data_last_d;
         mem_en_q       <= mem_en_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         ret1_vld_q     <= ret1_vld_d;
         ret1_own_q     <= ret1_own_d;
         ret2_vld_q     <= ret1_vld_q;
         ret2_own_q     <= ret1_own_q;
      end
   end

   assign bus.f_gnt     = f_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.l_gnt     = l_gnt;
   assign bus.f_rvalid  = ret2_vld_q && (ret2_own_q == OwnFetch);
   assign bus.d_rvalid  = ret2_vld_q && (ret2_own_q == OwnData);
   assign bus.l_rvalid  = ret2_vld_q && (ret2_own_q == OwnLoad);
   assign bus.rdata     = bus.mem_rdata;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule
